// File: rtl/vga_scaled_fetch_if.sv
// vga_scaled_fetch_if: fetch bus between the scaler and the pixel memory
interface vga_scaled_fetch_if #(
  parameter int AW  = 16,
  parameter int BPP = 12
) ();
  logic [AW-1:0]  o_addr;
  logic           o_fetch;
  logic [BPP-1:0] i_pixel;
  modport master (output o_addr, output o_fetch, input i_pixel);
  modport slave  (input o_addr, input o_fetch, output i_pixel);
endinterface

// File: rtl/vga_scaled_fetch.sv
// vga_scaled_fetch: display position tracker with integer source scaling, fetch addressing and border fill
module vga_scaled_fetch #(
  parameter int BITS_PER_COLOR = 4,
  parameter int HW             = 12,
  parameter int VW             = 12,
  parameter int AW             = 16,
  parameter int RD_LATENCY     = 1,
  localparam int BPP           = 3 * BITS_PER_COLOR
) (
  input  logic              i_pixclk,
  input  logic              i_reset,
  input  logic [HW-1:0]     i_width,
  input  logic [VW-1:0]     i_height,
  input  logic [HW-1:0]     i_src_width,
  input  logic [VW-1:0]     i_src_height,
  input  logic [2:0]        i_hscale,
  input  logic [2:0]        i_vscale,
  input  logic [BPP-1:0]    i_border,
  input  logic              i_rd,
  input  logic              i_newline,
  input  logic              i_newframe,
  output logic [HW-1:0]     o_xpos,
  output logic [VW-1:0]     o_ypos,
  output logic [BPP-1:0]    o_pixel,
  vga_scaled_fetch_if.master mem
);
  logic [HW-1:0]  srcw_q, srcw_d, xpos_q, xpos_d, sx_q, sx_d;
  logic [VW-1:0]  srch_q, srch_d, ypos_q, ypos_d, sy_q, sy_d;
  logic [2:0]     hs_q, hs_d, vs_q, vs_d, hrep_q, hrep_d, vrep_q, vrep_d;
  logic [AW-1:0]  rowbase_q, rowbase_d;
  logic           in_image, dvalid, unused_height;
  assign unused_height = ^i_height;
  assign in_image      = (sx_q < srcw_q) && (sy_q < srch_q);
  assign mem.o_addr    = rowbase_q + AW'(sx_q);
  assign mem.o_fetch   = i_rd && in_image;
  assign o_xpos        = xpos_q;
  assign o_ypos        = ypos_q;
  always_comb begin
    srcw_d    = srcw_q;
    srch_d    = srch_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    xpos_d    = xpos_q;
    hrep_d    = hrep_q;
    sx_d      = sx_q;
    ypos_d    = ypos_q;
    vrep_d    = vrep_q;
    sy_d      = sy_q;
    rowbase_d = rowbase_q;
    if (i_newframe) begin
      srcw_d    = i_src_width;
      srch_d    = i_src_height;
      hs_d      = i_hscale;
      vs_d      = i_vscale;
      xpos_d    = '0;
      hrep_d    = '0;
      sx_d      = '0;
      ypos_d    = '0;
      vrep_d    = '0;
      sy_d      = '0;
      rowbase_d = '0;
    end else if (i_newline) begin
      xpos_d = '0;
      hrep_d = '0;
      sx_d   = '0;
      ypos_d = ypos_q + 1'b1;
      vrep_d = vrep_q + 3'd1;
      if (vrep_q == vs_q) begin
        vrep_d    = '0;
        sy_d      = &sy_q ? sy_q : sy_q + 1'b1;
        rowbase_d = rowbase_q + AW'(srcw_q);
      end
    end else if (i_rd) begin
      if (xpos_q == i_width - 1'b1) begin
        xpos_d = '0;
        hrep_d = '0;
        sx_d   = '0;
      end else begin
        xpos_d = xpos_q + 1'b1;
        hrep_d = hrep_q + 3'd1;
        if (hrep_q == hs_q) begin
          hrep_d = '0;
          sx_d   = &sx_q ? sx_q : sx_q + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      srcw_q    <= i_src_width;
      srch_q    <= i_src_height;
      hs_q      <= i_hscale;
      vs_q      <= i_vscale;
      xpos_q    <= '0;
      hrep_q    <= '0;
      sx_q      <= '0;
      ypos_q    <= '0;
      vrep_q    <= '0;
      sy_q      <= '0;
      rowbase_q <= '0;
    end else begin
      srcw_q    <= srcw_d;
      srch_q    <= srch_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      xpos_q    <= xpos_d;
      hrep_q    <= hrep_d;
      sx_q      <= sx_d;
      ypos_q    <= ypos_d;
      vrep_q    <= vrep_d;
      sy_q      <= sy_d;
      rowbase_q <= rowbase_d;
    end
  end
  // valid tracks in_image rather than o_fetch so blanking cycles still carry memory data
  if (RD_LATENCY == 0) begin : g_nopipe
    assign dvalid = in_image;
  end else begin : g_pipe
    logic [RD_LATENCY-1:0] vpipe_q;
    always_ff @(posedge i_pixclk) begin
      if (i_reset) vpipe_q <= '0;
      else vpipe_q <= (vpipe_q << 1) | RD_LATENCY'(in_image);
    end
    assign dvalid = vpipe_q[RD_LATENCY-1];
  end
  always_ff @(posedge i_pixclk) begin
    if (i_reset) o_pixel <= '0;
    else o_pixel <= dvalid ? mem.i_pixel : i_border;
  end
endmodule

// File: tb/tb_vga_scaled_fetch.sv
// tb_vga_scaled_fetch: directed checks of scaling, addressing, latency alignment and reset
module tb_vga_scaled_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rd, nl, nf;
  logic [11:0] width, height, sw, sh, border;
  logic [2:0] hsc, vsc;
  logic [11:0] x1, y1, x3, y3, p1, p3;
  logic [11:0] r1;
  logic [11:0] r3 [3];
  int n_chk = 0;
  int n_fail = 0;
  vga_scaled_fetch_if #(.AW(16), .BPP(12)) m1 ();
  vga_scaled_fetch_if #(.AW(16), .BPP(12)) m3 ();
  vga_scaled_fetch #(.RD_LATENCY(1)) dut1 (
    .i_pixclk(clk), .i_reset(rst), .i_width(width), .i_height(height),
    .i_src_width(sw), .i_src_height(sh), .i_hscale(hsc), .i_vscale(vsc),
    .i_border(border), .i_rd(rd), .i_newline(nl), .i_newframe(nf),
    .o_xpos(x1), .o_ypos(y1), .o_pixel(p1), .mem(m1.master)
  );
  vga_scaled_fetch #(.RD_LATENCY(3)) dut3 (
    .i_pixclk(clk), .i_reset(rst), .i_width(width), .i_height(height),
    .i_src_width(sw), .i_src_height(sh), .i_hscale(hsc), .i_vscale(vsc),
    .i_border(border), .i_rd(rd), .i_newline(nl), .i_newframe(nf),
    .o_xpos(x3), .o_ypos(y3), .o_pixel(p3), .mem(m3.master)
  );
  always @(posedge clk) begin
    r1    <= m1.o_addr[11:0];
    r3[0] <= m3.o_addr[11:0];
    r3[1] <= r3[0];
    r3[2] <= r3[1];
  end
  assign m1.i_pixel = r1;
  assign m3.i_pixel = r3[2];

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [11:0] w, input logic [11:0] h, input logic [2:0] hs,
                       input logic [2:0] vs, input logic [11:0] b);
    sw = w; sh = h; hsc = hs; vsc = vs; border = b;
    rd = 0; nl = 0; nf = 1;
    adv();
    nf = 0;
  endtask

  task automatic test_reset();
    width = 640; height = 480; sw = 640; sh = 480; hsc = 0; vsc = 0; border = 12'hF00;
    rd = 0; nl = 0; nf = 0; rst = 1;
    adv(); adv();
    rst = 0;
    @(negedge clk);
    n_chk++; if (x1 !== 12'd0) begin n_fail++; $display("FAIL reset_xpos got %0d want 0", x1); end
    n_chk++; if (y1 !== 12'd0) begin n_fail++; $display("FAIL reset_ypos got %0d want 0", y1); end
    n_chk++; if (m1.o_addr !== 16'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", m1.o_addr); end
    n_chk++; if (m1.o_fetch !== 1'b0) begin n_fail++; $display("FAIL reset_fetch got %b want 0", m1.o_fetch); end
    n_chk++; if (p1 !== 12'd0) begin n_fail++; $display("FAIL reset_pixel got %h want 0", p1); end
    n_chk++; if (p3 !== 12'd0) begin n_fail++; $display("FAIL reset_pixel3 got %h want 0", p3); end
    adv();
  endtask

  task automatic test_row();
    frame(640, 480, 0, 0, 12'hF00);
    rd = 1;
    for (int k = 0; k < 640; k++) begin
      @(negedge clk);
      n_chk++; if (m1.o_addr !== 16'(k)) begin n_fail++; $display("FAIL row_addr k=%0d got %0d want %0d", k, m1.o_addr, k); end
      n_chk++; if (m1.o_fetch !== 1'b1) begin n_fail++; $display("FAIL row_fetch k=%0d got %b want 1", k, m1.o_fetch); end
      n_chk++; if (x1 !== 12'(k)) begin n_fail++; $display("FAIL row_xpos k=%0d got %0d want %0d", k, x1, k); end
      if (k >= 2) begin
        n_chk++; if (p1 !== 12'(k - 2)) begin n_fail++; $display("FAIL row_pixel k=%0d got %h want %h", k, p1, 12'(k - 2)); end
      end
      if (k >= 4) begin
        n_chk++; if (p3 !== 12'(k - 4)) begin n_fail++; $display("FAIL row_pixel3 k=%0d got %h want %h", k, p3, 12'(k - 4)); end
      end
      adv();
    end
    rd = 0;
    @(negedge clk);
    n_chk++; if (x1 !== 12'd0) begin n_fail++; $display("FAIL row_wrap got %0d want 0", x1); end
    adv();
    nl = 1;
    adv();
    nl = 0; rd = 1;
    @(negedge clk);
    n_chk++; if (m1.o_addr !== 16'd640) begin n_fail++; $display("FAIL row1_addr got %0d want 640", m1.o_addr); end
    n_chk++; if (y1 !== 12'd1) begin n_fail++; $display("FAIL row1_ypos got %0d want 1", y1); end
    adv();
    rd = 0;
  endtask

  task automatic test_scale();
    frame(320, 240, 1, 1, 12'hF00);
    for (int r = 0; r < 3; r++) begin
      rd = 1;
      for (int k = 0; k < 640; k++) begin
        @(negedge clk);
        n_chk++;
        if (m1.o_addr !== 16'((r / 2) * 320 + k / 2)) begin
          n_fail++; $display("FAIL scale_addr r=%0d k=%0d got %0d want %0d", r, k, m1.o_addr, (r / 2) * 320 + k / 2);
        end
        n_chk++; if (m1.o_fetch !== 1'b1) begin n_fail++; $display("FAIL scale_fetch r=%0d k=%0d got %b want 1", r, k, m1.o_fetch); end
        adv();
      end
      rd = 0; nl = 1;
      adv();
      nl = 0;
    end
  endtask

  task automatic test_border();
    frame(100, 480, 0, 0, 12'hF00);
    rd = 1;
    for (int k = 0; k < 640; k++) begin
      @(negedge clk);
      n_chk++; if (m1.o_fetch !== (k < 100)) begin n_fail++; $display("FAIL border_fetch k=%0d got %b want %b", k, m1.o_fetch, k < 100); end
      if (k >= 2) begin
        n_chk++;
        if (p1 !== ((k - 2) < 100 ? 12'(k - 2) : 12'hF00)) begin
          n_fail++; $display("FAIL border_pixel k=%0d got %h want %h", k, p1, ((k - 2) < 100 ? 12'(k - 2) : 12'hF00));
        end
      end
      adv();
    end
    rd = 0;
  endtask

  task automatic test_latency();
    frame(200, 480, 0, 0, 12'hABC);
    rd = 1;
    for (int k = 0; k < 640; k++) begin
      @(negedge clk);
      n_chk++; if (m3.o_addr !== 16'(k)) begin n_fail++; $display("FAIL lat_addr k=%0d got %0d want %0d", k, m3.o_addr, k); end
      if (k >= 4) begin
        n_chk++;
        if (p3 !== ((k - 4) < 200 ? 12'(k - 4) : 12'hABC)) begin
          n_fail++; $display("FAIL lat_pixel3 k=%0d got %h want %h", k, p3, ((k - 4) < 200 ? 12'(k - 4) : 12'hABC));
        end
      end
      adv();
    end
    rd = 0;
  endtask

  task automatic test_midframe();
    frame(640, 480, 0, 0, 12'hF00);
    rd = 1;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) hsc = 3;
      @(negedge clk);
      n_chk++; if (m1.o_addr !== 16'(k)) begin n_fail++; $display("FAIL mid_addr k=%0d got %0d want %0d", k, m1.o_addr, k); end
      adv();
    end
    rd = 0; nl = 1;
    adv();
    nl = 0; nf = 1;
    adv();
    nf = 0; rd = 1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_chk++; if (m1.o_addr !== 16'(k / 4)) begin n_fail++; $display("FAIL mid_scaled_addr k=%0d got %0d want %0d", k, m1.o_addr, k / 4); end
      adv();
    end
    rd = 0;
  endtask

  task automatic test_reset_midline();
    frame(640, 480, 0, 0, 12'hF00);
    nl = 1;
    repeat (5) adv();
    nl = 0; rd = 1;
    repeat (200) adv();
    @(negedge clk);
    n_chk++; if (x1 !== 12'd200) begin n_fail++; $display("FAIL pre_reset_xpos got %0d want 200", x1); end
    n_chk++; if (y1 !== 12'd5) begin n_fail++; $display("FAIL pre_reset_ypos got %0d want 5", y1); end
    n_chk++; if (m1.o_addr !== 16'd3400) begin n_fail++; $display("FAIL pre_reset_addr got %0d want 3400", m1.o_addr); end
    adv();
    rst = 1; nl = 1;
    adv();
    rst = 0; nl = 0; rd = 0;
    @(negedge clk);
    n_chk++; if (x1 !== 12'd0) begin n_fail++; $display("FAIL mid_reset_xpos got %0d want 0", x1); end
    n_chk++; if (y1 !== 12'd0) begin n_fail++; $display("FAIL mid_reset_ypos got %0d want 0", y1); end
    n_chk++; if (m1.o_addr !== 16'd0) begin n_fail++; $display("FAIL mid_reset_addr got %0d want 0", m1.o_addr); end
    n_chk++; if (m1.o_fetch !== 1'b0) begin n_fail++; $display("FAIL mid_reset_fetch got %b want 0", m1.o_fetch); end
    n_chk++; if (p1 !== 12'd0) begin n_fail++; $display("FAIL mid_reset_pixel got %h want 0", p1); end
    n_chk++; if (p3 !== 12'd0) begin n_fail++; $display("FAIL mid_reset_pixel3 got %h want 0", p3); end
    adv();
  endtask

  initial begin
    test_reset();
    test_row();
    test_scale();
    test_border();
    test_latency();
    test_midframe();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_scaled_fetch.md
Name: vga_scaled_fetch

Overview:
- Successor to the pixel position tracker in the HDMI test-pattern path.
- Tracks display X/Y and integer-scales a smaller source image by per-axis pixel/line replication (1x–8x).
- Generates a linear fetch address for an external ROM or framebuffer and compensates a parametrised read latency.
- Substitutes a border colour for pixels outside the source image; sits between the video timing generator and the pixel memory.

Parameters:
BITS_PER_COLOR, 4, bits per colour channel; BPP = 3*BITS_PER_COLOR
HW, 12, width of horizontal counters and width inputs
VW, 12, width of vertical counters and height inputs
AW, 16, fetch address width
RD_LATENCY, 1, cycles from o_addr/o_fetch to valid i_pixel (range 0..7)

Ports:
i_pixclk  in  1  pixel clock; all logic on posedge
i_reset  in  1  synchronous, active-high reset
i_width  in  HW  active display width
i_height  in  VW  active display height
i_src_width  in  HW  source image width
i_src_height  in  VW  source image height
i_hscale  in  3  horizontal replication minus one (0=1x .. 7=8x)
i_vscale  in  3  vertical replication minus one
i_border  in  BPP  colour shown outside the source image
i_rd  in  1  active-pixel strobe from timing generator
i_newline  in  1  end-of-line pulse
i_newframe  in  1  start-of-frame pulse
o_xpos  out  HW  display x (registered counter)
o_ypos  out  VW  display y (registered counter)
o_addr  out  AW  fetch address = rowbase + sx, mod 2^AW
o_fetch  out  1  i_rd && in_image (combinational from registers)
i_pixel  in  BPP  pixel data, valid RD_LATENCY cycles after o_addr
o_pixel  out  BPP  registered output pixel

Behaviour:
- Shadow registers hold src_w, src_h, hs, vs. They load from the inputs on reset and on i_newframe only; mid-frame input changes have no effect.
- Horizontal, on i_rd: xpos+1, hrep+1. When hrep==hs: hrep<=0, sx+1. When xpos==i_width-1: xpos, hrep and sx <=0.
- Vertical, on i_newline: ypos+1, vrep+1. When vrep==vs: vrep<=0, sy+1, rowbase<=rowbase+src_w (AW-bit wrap).
- i_newline also forces xpos, hrep and sx to 0 for resync; this takes priority over an i_rd in the same cycle.
- i_newframe zeroes ypos, vrep, sy, rowbase, xpos, hrep and sx, and loads the shadows.
- Priority: i_reset > i_newframe > i_newline > i_rd.
- No multiplier: the address is built incrementally.
- in_image = (sx < src_w) && (sy < src_h), unsigned compares.
- o_addr is driven every cycle, regardless of in_image.
- Latency pipe: an in_image-qualified valid bit passes through a RD_LATENCY-deep shift register (a wire when RD_LATENCY=0).
- Output stage: o_pixel <= delayed_valid ? i_pixel : i_border. o_pixel therefore reflects a given i_rd cycle exactly RD_LATENCY+1 cycles later.
- Reset: all counters, rowbase and the valid pipe clear to 0; o_pixel=0, o_xpos=0, o_ypos=0, o_addr=0; o_fetch=0 after reset.
- Reset mid-line takes effect the next edge with no partial state retained.
- ypos has no wrap at i_height; the frame boundary comes from i_newframe. i_height is informational for the bench and for future blanking.
- sx and sy saturate at all-ones (no wrap); in_image is 0 there.
- Outside the i_rd window o_pixel still updates, with border or memory data.

Test Plan:
- Reset, then i_width=640, src 640x480, scale 0/0, RD_LATENCY=1 -> row 0: o_addr 0..639 with o_fetch=1. After i_newline, row 1 starts at o_addr=640. o_xpos wraps 639->0.
- hscale=1, vscale=1, src 320x240 -> o_addr per row: 0,0,1,1,..,319,319. Display rows 0 and 1 use rowbase 0; row 2 uses rowbase 320.
- src_width=100, i_border=12'hF00, display 640 -> o_fetch=0 for xpos>=100. o_pixel=12'hF00 from 2 cycles after xpos=100 until line end.
- RD_LATENCY=3, bench ROM returns i_pixel = address 3 cycles after o_addr -> o_pixel equals the address issued 4 cycles earlier. Border insertion stays aligned with it.
- hscale changed 0->3 mid-frame -> addresses unchanged until the next i_newframe, then each address repeats 4 times.
- i_reset asserted at xpos=200 of row 5, with i_newline and i_rd also high -> next cycle all counters 0, o_pixel=0, o_addr=0.
